mem_nr1w_clr: RTL and testbench
===============================

MEM_NR1W_CLR -- requirements
Module: mem_nr1w_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter WORD, default 1024, number of entries (power of two, >= 2); ADDR_WIDTH = LOG2(WORD).
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (>= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port addr_w  input  32  write address; only bits [ADDR_WIDTH-1:0] used.
REQ-007 SHALL have port in_w  input  WIDTH  write data.
REQ-008 SHALL have port we_w  input  1  write enable.
REQ-009 SHALL have port be_w  input  WIDTH/8  byte enables; bit k qualifies in_w[8k+7:8k].
REQ-010 SHALL have port addr_r  input  NREAD*32  packed read addresses; port p at [32p+31:32p], low ADDR_WIDTH bits used.
REQ-011 SHALL have port out_r  output  NREAD*WIDTH  packed registered read data; port p at [WIDTH*p+WIDTH-1:WIDTH*p].
REQ-012 SHALL have port busy  output  1  high while the post-reset clear sequence runs.

Function
REQ-013 SHALL ignore address bits at and above ADDR_WIDTH, so addresses wrap modulo WORD.
REQ-014 SHALL, on an edge with we_w=1 and busy=0, write byte k of in_w to mem[addr_w] for each be_w[k]=1 and leave other bytes unchanged.
REQ-015 SHALL treat we_w=1 with be_w all zero as no write.
REQ-016 SHALL register every read port: out_r port p after edge n reflects mem[addr_r port p] as sampled at edge n (latency 1 cycle).
REQ-017 SHALL serve all NREAD ports independently each cycle, including identical addresses on several ports.
REQ-018 SHALL implement a two-state FSM: CLEAR (busy=1) and READY (busy=0).
REQ-019 SHALL, in CLEAR, write all-zero to mem[ptr] and increment ptr on each edge; on the edge that writes ptr=WORD-1, move to READY.
REQ-020 SHALL keep busy=1 for exactly WORD cycles after the last edge at which rst was sampled high.
REQ-021 SHALL ignore we_w entirely in CLEAR; the write is dropped, not queued.
REQ-022 SHALL register out_r as all-zero on every edge taken in CLEAR, regardless of addr_r.
REQ-023 SHALL never return to CLEAR except through rst.

Reset
REQ-024 SHALL, on an edge with rst=1, set state=CLEAR, busy=1, ptr=0 and out_r=0, and perform no memory write.
REQ-025 SHALL, when rst is reasserted mid-clear or in READY, abandon any progress and restart the clear at ptr=0 on the first edge after rst falls.
REQ-026 SHALL not rely on initial blocks for functional contents; after busy falls every entry reads zero.

Configuration
REQ-027 SHALL honour macro MEM_NR1W_BYPASS_EN.
REQ-028 SHALL, with MEM_NR1W_BYPASS_EN defined, forward a same-edge write: a read port whose address equals addr_w on an edge with an effective write registers the merged word (enabled bytes from in_w, other bytes from old mem).
REQ-029 SHALL, without MEM_NR1W_BYPASS_EN, be read-before-write: the read port registers the pre-write contents, and the new data is visible from the next read onward.
REQ-030 SHALL apply forwarding only in READY; CLEAR behaviour is identical in both builds.

Verification
REQ-031 Reset then idle with WORD=16: busy=1 for exactly 16 cycles after rst falls, then 0; read all 16 addresses -> every out_r 0.
REQ-032 READY, write addr 5 data 0xDEADBEEF be=4'b1111, next cycle read addr 5 on both ports -> out_r both 0xDEADBEEF one cycle later.
REQ-033 Over 0xDEADBEEF at addr 5, write 0x11223344 be=4'b0101 -> addr 5 reads 0xDE22BE44.
REQ-034 Same edge write addr 7 data 0xA5A5A5A5 be=1111 and read addr 7 (old 0): bypass build -> 0xA5A5A5A5; non-bypass -> 0x00000000, then 0xA5A5A5A5 next read.
REQ-035 Write addr 3 data 0x1 during CLEAR and read addr 3+WORD (wrap) after busy falls -> 0x0, with out_r 0 throughout CLEAR.
REQ-036 Assert rst for 1 cycle at ptr=8 mid-clear -> busy stays high for a full WORD cycles after rst falls; all entries read zero afterward.

Source files
------------

// File: rtl/mem_nr1w_clr.sv
// rtl/mem_nr1w_clr.sv - N-read/1-write byte-enabled RAM with a post-reset zero-clear sequence
// Optional same-edge write forwarding to read ports: define MEM_NR1W_BYPASS_EN.
module mem_nr1w_clr #(
    parameter int WIDTH = 32,
    parameter int WORD  = 1024,
    parameter int NREAD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              addr_w,
    input  logic [WIDTH-1:0]         in_w,
    input  logic                     we_w,
    input  logic [WIDTH/8-1:0]       be_w,
    input  logic [NREAD*32-1:0]      addr_r,
    output logic [NREAD*WIDTH-1:0]   out_r,
    output logic                     busy
);

    localparam int ADDR_WIDTH = $clog2(WORD);
    localparam int NBYTE      = WIDTH / 8;

`ifdef MEM_NR1W_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [NREAD*WIDTH-1:0]  out_q, out_d;
    logic [WIDTH-1:0]        mem_q [WORD];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [WIDTH-1:0]        wr_data;
    logic [ADDR_WIDTH-1:0]   user_waddr;
    logic [WIDTH-1:0]        merged;
    logic                    user_wr;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    // Upper address bits are deliberately ignored so addresses wrap modulo WORD.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_w, addr_r};

    assign user_waddr = addr_w[ADDR_WIDTH-1:0];
    assign user_wr    = we_w && (|be_w) && (state_q == READY);

    always_comb begin
        merged = mem_q[user_waddr];
        for (int k = 0; k < NBYTE; k++) begin
            if (be_w[k]) begin
                merged[8*k +: 8] = in_w[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = user_waddr;
        wr_data = merged;
        if (!rst) begin
            if (state_q == CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = ptr_q;
                wr_data = '0;
                ptr_d   = ptr_q + 1'b1;
                if (ptr_q == ADDR_WIDTH'(WORD - 1)) begin
                    state_d = READY;
                end
            end else begin
                wr_en = user_wr;
            end
        end
    end

    always_comb begin
        out_d   = '0;
        rd_addr = '0;
        if (!rst && state_q == READY) begin
            for (int p = 0; p < NREAD; p++) begin
                rd_addr = addr_r[32*p +: ADDR_WIDTH];
                if (BYPASS && user_wr && rd_addr == user_waddr) begin
                    out_d[WIDTH*p +: WIDTH] = merged;
                end else begin
                    out_d[WIDTH*p +: WIDTH] = mem_q[rd_addr];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
        end
    end

    // Storage has no reset; the clear sequence provides the zero contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign out_r = out_q;
    assign busy  = (state_q == CLEAR);

endmodule

// File: tb/tb_mem_nr1w_clr.sv
// tb/tb_mem_nr1w_clr.sv - self-checking bench for mem_nr1w_clr (WORD=16, NREAD=2)
module tb_mem_nr1w_clr;

    localparam int WIDTH = 32;
    localparam int WORD  = 16;
    localparam int NREAD = 2;

`ifdef MEM_NR1W_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [31:0]             addr_w;
    logic [WIDTH-1:0]        in_w;
    logic                    we_w;
    logic [WIDTH/8-1:0]      be_w;
    logic [NREAD*32-1:0]     addr_r;
    logic [NREAD*WIDTH-1:0]  out_r;
    logic                    busy;

    mem_nr1w_clr #(.WIDTH(WIDTH), .WORD(WORD), .NREAD(NREAD)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr_w (addr_w),
        .in_w   (in_w),
        .we_w   (we_w),
        .be_w   (be_w),
        .addr_r (addr_r),
        .out_r  (out_r),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: contents seen by a reader, and how many clear cycles remain.
    logic [WIDTH-1:0] m_mem [WORD];
    int               m_left  = 0;
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_out [NREAD];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORD; i++) m_mem[i] = '0;
            for (int p = 0; p < NREAD; p++) m_out[p] = '0;
            m_left  = WORD;
            m_valid = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
            for (int p = 0; p < NREAD; p++) m_out[p] = '0;
        end else begin
            int wa;
            bit wen;
            logic [WIDTH-1:0] nw;
            wa  = int'(addr_w % WORD);
            wen = we_w && (be_w != 0);
            nw  = m_mem[wa];
            for (int k = 0; k < WIDTH/8; k++)
                if (be_w[k]) nw[8*k +: 8] = in_w[8*k +: 8];
            for (int p = 0; p < NREAD; p++) begin
                int ra;
                ra = int'(addr_r[32*p +: 32] % WORD);
                m_out[p] = (BYP && wen && ra == wa) ? nw : m_mem[ra];
            end
            if (wen) m_mem[wa] = nw;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", 64'(busy), 64'(m_left > 0));
            for (int p = 0; p < NREAD; p++)
                chk($sformatf("out_r[%0d]", p), 64'(out_r[WIDTH*p +: WIDTH]), 64'(m_out[p]));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rd(input logic [31:0] a0, input logic [31:0] a1);
        addr_r = {a1, a0};
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        addr_w = a; in_w = d; be_w = be; we_w = 1'b1;
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy && cnt < 40) begin
            step();
            cnt++;
        end
        chk(name, 64'(cnt), 64'(WORD));
    endtask

    initial begin
        rst = 1'b1; we_w = 1'b0; addr_w = '0; in_w = '0; be_w = '0;
        set_rd(32'd3, 32'd9);
        @(negedge clk);
        step();
        chk("reset_busy", 64'(busy), 64'd1);
        chk("reset_out", 64'(out_r), 64'd0);

        // Clear with a write to addr 3 attempted throughout; it must be dropped.
        rst = 1'b0;
        wr(32'd3, 32'h1, 4'hF);
        set_rd(32'd3, 32'd7);
        count_busy("clear_len");
        we_w = 1'b0;
        set_rd(32'd3 + WORD, 32'd3);
        step();
        chk("wrap_read_3", 64'(out_r[31:0]), 64'd0);

        for (int i = 0; i < WORD; i++) begin
            set_rd(32'(i), 32'(WORD - 1 - i));
            step();
            chk("all_zero", 64'(out_r), 64'd0);
        end

        wr(32'd5, 32'hDEADBEEF, 4'hF);
        step();
        we_w = 1'b0;
        set_rd(32'd5, 32'd5);
        step();
        chk("full_write", 64'(out_r), {32'hDEADBEEF, 32'hDEADBEEF});

        wr(32'd5, 32'h11223344, 4'b0101);
        step();
        we_w = 1'b0;
        step();
        chk("byte_merge", 64'(out_r[31:0]), 64'hDE22BE44);

        wr(32'd5, 32'hFFFFFFFF, 4'b0000);
        step();
        we_w = 1'b0;
        step();
        chk("be_zero", 64'(out_r[63:32]), 64'hDE22BE44);

        wr(32'd7, 32'hA5A5A5A5, 4'hF);
        set_rd(32'd7, 32'd5);
        step();
        chk("same_edge", 64'(out_r[31:0]), BYP ? 64'hA5A5A5A5 : 64'h0);
        chk("other_port", 64'(out_r[63:32]), 64'hDE22BE44);
        we_w = 1'b0;
        step();
        chk("after_write", 64'(out_r[31:0]), 64'hA5A5A5A5);

        for (int i = 0; i < 40; i++) begin
            wr($urandom_range(0, 47), $urandom, 4'($urandom_range(0, 15)));
            we_w = 1'($urandom_range(0, 1));
            set_rd($urandom_range(0, 47), $urandom_range(0, 47));
            step();
        end
        we_w = 1'b0;

        // Reset from READY, then a second reset landing mid-clear at ptr=8.
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr(32'd2, 32'h55, 4'hF);
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("mid_clear_restart");
        we_w = 1'b0;
        for (int i = 0; i < WORD; i++) begin
            set_rd(32'(i), 32'(i + WORD));
            step();
            chk("zero_after_restart", 64'(out_r), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
